// File: rtl/gb_tile_reader_pkg.sv
// ============================================================================
// Module   : gb_tile_reader_pkg
// Purpose  : Shared state encoding and FIFO sizing for the tile reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_tile_reader_pkg;

  // Burst controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Output FIFO depth; also the total read credit available to the controller
  localparam int unsigned C_FIFO_DEPTH = 4;

endpackage : gb_tile_reader_pkg

`default_nettype wire

// File: rtl/gb_rd_fifo.sv
// ============================================================================
// Module   : gb_rd_fifo
// Purpose  : Small synchronous FIFO with occupancy count; push and pop may
//            occur in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] c_ptr_last = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full push or an empty pop is dropped so the pointers never cross
  assign w_do_push = push && (r_count != c_cnt_full);
  assign w_do_pop  = pop && (r_count != '0);

  assign pop_data = r_mem[r_rd_ptr];
  assign empty    = (r_count == '0);
  assign full     = (r_count == c_cnt_full);
  assign count    = r_count;

  // Storage, pointers and occupancy; simultaneous push and pop keep count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : gb_rd_fifo

`default_nettype wire

// File: rtl/gb_tile_reader.sv
// ============================================================================
// Module   : gb_tile_reader
// Purpose  : Reads a burst of consecutive global-buffer words and streams
//            them out over a valid/ready interface, with credit-based read
//            issue so the output FIFO can never overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_tile_reader
  import gb_tile_reader_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] index,
  output logic [DATA_BITS-1:0] data_in,
  input  logic [DATA_BITS-1:0] ram_rdata,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_last
);

  localparam int CNT_W = $clog2(C_FIFO_DEPTH + 1);
  localparam logic [ADDR_BITS:0]   c_len_one  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] c_addr_one = ADDR_BITS'(1);
  localparam logic [CNT_W:0]       c_credits  = (CNT_W+1)'(C_FIFO_DEPTH);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_BITS:0]   r_len;
  logic [ADDR_BITS:0]   r_issue_cnt;
  logic [ADDR_BITS:0]   r_out_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_inflight;
  logic                 r_done;

  logic [CNT_W-1:0]     w_fifo_count;
  logic [DATA_BITS-1:0] w_fifo_dout;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [CNT_W:0]       w_occupancy;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_accept;
  logic                 w_done_set;
  logic                 w_xfer;
  logic                 w_last_word;

  // Words buffered plus the single read that may be returning this cycle
  assign w_occupancy = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_inflight);
  assign w_credit    = (w_occupancy < c_credits);

  assign w_xfer      = m_valid && m_ready;
  assign w_last_word = (r_out_cnt == (r_len - c_len_one));

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign ram_en  = w_issue;
  assign wr_en   = 1'b0;
  assign data_in = '0;
  assign index   = r_addr;
  assign m_valid = !w_fifo_empty;
  assign m_data  = m_valid ? w_fifo_dout : '0;
  assign m_last  = m_valid && w_last_word;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, read issue and completion decode
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_done_set = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_issue_cnt == (r_len - c_len_one)) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_xfer && w_last_word) begin
          w_done_set  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping: captured request, read address and word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_addr      <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
    end else if (w_accept) begin
      r_len       <= len;
      r_addr      <= base_addr;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
    end else begin
      if (w_issue) begin
        r_addr      <= r_addr + c_addr_one;
        r_issue_cnt <= r_issue_cnt + c_len_one;
      end
      if (w_xfer) begin
        r_out_cnt <= r_out_cnt + c_len_one;
      end
    end
  end

  // Read-return tracking and the one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_done_set;
    end
  end

  gb_rd_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (r_inflight),
    .push_data (ram_rdata),
    .pop       (w_xfer),
    .pop_data  (w_fifo_dout),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

endmodule : gb_tile_reader

`default_nettype wire

// File: doc/gb_tile_reader.md
GB_TILE_READER -- requirements
Module: gb_tile_reader

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, global buffer address width.
REQ-002 SHALL have parameter DATA_BITS, default 8, global buffer word width.
REQ-003 SHALL have port clk  input  1  single clock; every flop is rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_BITS  first buffer address; captured with start.
REQ-007 SHALL have port len  input  ADDR_BITS+1  word count, 0..2^ADDR_BITS; captured with start.
REQ-008 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the burst completes.
REQ-010 SHALL have port ram_en  output  1  buffer enable; high only in a read-issue cycle.
REQ-011 SHALL have port wr_en  output  1  buffer write enable; held at 0.
REQ-012 SHALL have port index  output  ADDR_BITS  buffer address.
REQ-013 SHALL have port data_in  output  DATA_BITS  buffer write data; held at 0.
REQ-014 SHALL have port ram_rdata  input  DATA_BITS  buffer registered read data, valid one cycle after the ram_en cycle.
REQ-015 SHALL have port m_valid  output  1  stream word available.
REQ-016 SHALL have port m_ready  input  1  downstream accepts the word.
REQ-017 SHALL have port m_data  output  DATA_BITS  stream word.
REQ-018 SHALL have port m_last  output  1  qualifies the final word of the burst.

Function
REQ-019 SHALL implement the states IDLE, ISSUE and DRAIN.
REQ-020 SHALL move IDLE->ISSUE on start with len>0; start with len==0 SHALL stay in IDLE and pulse done in the next cycle, with no ram_en.
REQ-021 SHALL ignore start while busy, with no effect on the burst.
REQ-022 In ISSUE, SHALL assert ram_en with wr_en=0 and index=(base_addr+k) mod 2^ADDR_BITS for k=0..len-1, in ascending order, one read per cycle, whenever a credit exists.
REQ-023 Credit rule: a read SHALL issue only if fifo_count + reads_in_flight < 4, where a read counts as in flight until ram_rdata is written to the FIFO.
REQ-024 SHALL write ram_rdata to the 4-entry output FIFO exactly one cycle after each ram_en cycle; the FIFO SHALL never overflow.
REQ-025 SHALL move ISSUE->DRAIN when the last read is issued.
REQ-026 In DRAIN, SHALL move DRAIN->IDLE and pulse done in the cycle after the last word transfers (m_valid&&m_ready&&m_last); busy SHALL fall in that same cycle.
REQ-027 Stream latency: for start in cycle 0 and no stall, ram_en SHALL be high in cycle 1, and m_valid SHALL be high in cycle 3 with the word at base_addr.
REQ-028 With m_ready held high, SHALL sustain one word per cycle after the first word.
REQ-029 Handshake: once m_valid is asserted, m_valid, m_data and m_last SHALL hold until m_ready; a word transfers on m_valid&&m_ready.
REQ-030 m_last SHALL be high only with word len-1.
REQ-031 Address wrap: base_addr=2^ADDR_BITS-1 with len=2 SHALL read 2^ADDR_BITS-1 and then 0.
REQ-032 len=2^ADDR_BITS SHALL read every address exactly once.
REQ-033 Simultaneous FIFO push and pop SHALL leave the count unchanged.

Reset
REQ-034 On rst_n low, asynchronously: state=IDLE; busy, done, ram_en, m_valid and m_last SHALL be 0; index, wr_en, data_in and m_data SHALL be 0; FIFO, counters and in-flight tracking SHALL be cleared.
REQ-035 Reset during a burst SHALL abandon the burst with no done, and read data returning after reset SHALL be discarded.

Structure
REQ-036 The shared package SHALL hold the state encoding (IDLE/ISSUE/DRAIN) and the FIFO depth constant (4).
REQ-037 The FIFO SHALL be one sub-module, gb_rd_fifo: a synchronous FIFO, parameterised by width and depth, with count output.

Verification
REQ-038 Scenario 1: buffer preloaded with mem[i]=i; start with base=0x10, len=4, m_ready=1 -> m_data 0x10,0x11,0x12,0x13 in cycles 3-6, m_last in cycle 6, done in cycle 7.
REQ-039 Scenario 2: same burst with m_ready=0 for cycles 3-10 -> at most 4 reads issued, m_data held at 0x10, no loss or duplication after release.
REQ-040 Scenario 3: base=0xFF, len=2 -> index sequence 0xFF then 0x00; stream 0xFF, 0x00.
REQ-041 Scenario 4: len=0 -> no ram_en, done 1 cycle after start; len=256 -> 256 words in order, m_last on word 255.
REQ-042 Scenario 5: start asserted again mid-burst -> ignored, output unchanged.
REQ-043 Scenario 6: rst_n low in cycle 5 of a len=8 burst -> all outputs 0 immediately, no done; a new burst afterwards completes correctly.
